instruction_cache: RTL and testbench

Blocking, direct-mapped instruction cache that answers the fetcher's PC requests and hands decoded-ready instruction words, with the request's warp ID and active mask, to the decoder. On a hit it responds one cycle after acceptance. On a miss it performs a single-word refill from instruction memory, then responds. It sits between the fetcher (upstream, valid/ready) and the decoder (downstream, valid/ready), with a request/response port to instruction memory.

---
 rtl/instruction_cache.sv | 196 +++++++++++++++++++
 tb/tb_instruction_cache.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// Blocking direct-mapped instruction cache, one instruction per line.
// Optional perf counters: define ICACHE_PERF_COUNTERS_EN.
module instruction_cache #(
    parameter int PcWidth    = 32,
    parameter int NumWarps   = 8,
    parameter int WarpWidth  = 32,
    parameter int InstrWidth = 32,
    parameter int NumLines   = 16,
    localparam int IdxWidth  = $clog2(NumLines),
    localparam int TagWidth  = PcWidth - IdxWidth,
    localparam int WidWidth  = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  fe_valid_i,
    output logic                  fe_ready_o,
    input  logic [PcWidth-1:0]    fe_pc_i,
    input  logic [WarpWidth-1:0]  fe_act_mask_i,
    input  logic [WidWidth-1:0]   fe_warp_id_i,
    output logic                  ic_valid_o,
    input  logic                  dec_ready_i,
    output logic [PcWidth-1:0]    ic_pc_o,
    output logic [WarpWidth-1:0]  ic_act_mask_o,
    output logic [WidWidth-1:0]   ic_warp_id_o,
    output logic [InstrWidth-1:0] ic_instr_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PcWidth-1:0]    mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [InstrWidth-1:0] mem_rsp_data_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);

    typedef logic [WidWidth-1:0]  wid_t;
    typedef logic [PcWidth-1:0]   pc_t;
    typedef logic [WarpWidth-1:0] act_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        MISS_WAIT,
        DELIVER
    } state_e;

    state_e state_q, state_d;

    logic [NumLines-1:0]   valid_q;
    logic [TagWidth-1:0]   tag_q  [NumLines];
    logic [InstrWidth-1:0] data_q [NumLines];

    pc_t                   req_pc_q;
    act_mask_t             req_mask_q;
    wid_t                  req_wid_q;
    logic [InstrWidth-1:0] fill_data_q;
    logic                  flushed_q;

    logic                  out_free;
    logic [IdxWidth-1:0]   lookup_idx;
    logic [TagWidth-1:0]   lookup_tag;
    logic                  lookup_hit;
    logic [IdxWidth-1:0]   req_idx;
    logic                  accept;
    logic                  hit_load;
    logic                  fill;
    logic                  deliver;

    assign out_free   = !ic_valid_o || dec_ready_i;
    assign lookup_idx = fe_pc_i[IdxWidth-1:0];
    assign lookup_tag = fe_pc_i[PcWidth-1:IdxWidth];
    assign lookup_hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign req_idx    = req_pc_q[IdxWidth-1:0];
    assign mem_req_addr_o = req_pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        fe_ready_o      = 1'b0;
        mem_req_valid_o = 1'b0;
        accept          = 1'b0;
        hit_load        = 1'b0;
        fill            = 1'b0;
        deliver         = 1'b0;
        unique case (state_q)
            IDLE: begin
                fe_ready_o = out_free && !flush_i && !rst_i;
                accept     = fe_valid_i && fe_ready_o;
                if (accept) begin
                    if (lookup_hit) hit_load = 1'b1;
                    else            state_d  = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_rsp_valid_i) begin
                    fill    = 1'b1;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                if (out_free) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Flush wins over a same-cycle fill so a stale word never becomes valid.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i)        valid_q <= '0;
        else if (fill && !flushed_q) valid_q[req_idx] <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_q[req_idx]  <= req_pc_q[PcWidth-1:IdxWidth];
            data_q[req_idx] <= mem_rsp_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_pc_q    <= '0;
            req_mask_q  <= '0;
            req_wid_q   <= '0;
            fill_data_q <= '0;
            flushed_q   <= 1'b0;
        end else begin
            if (accept) begin
                req_pc_q   <= fe_pc_i;
                req_mask_q <= fe_act_mask_i;
                req_wid_q  <= fe_warp_id_i;
                flushed_q  <= 1'b0;
            end else if (flush_i) begin
                flushed_q  <= 1'b1;
            end
            if (fill) fill_data_q <= mem_rsp_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ic_valid_o    <= 1'b0;
            ic_pc_o       <= '0;
            ic_act_mask_o <= '0;
            ic_warp_id_o  <= '0;
            ic_instr_o    <= '0;
        end else if (hit_load) begin
            ic_valid_o    <= 1'b1;
            ic_pc_o       <= fe_pc_i;
            ic_act_mask_o <= fe_act_mask_i;
            ic_warp_id_o  <= fe_warp_id_i;
            ic_instr_o    <= data_q[lookup_idx];
        end else if (deliver) begin
            ic_valid_o    <= 1'b1;
            ic_pc_o       <= req_pc_q;
            ic_act_mask_o <= req_mask_q;
            ic_warp_id_o  <= req_wid_q;
            ic_instr_o    <= fill_data_q;
        end else if (dec_ready_i) begin
            ic_valid_o    <= 1'b0;
        end
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_load && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (accept && !lookup_hit && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized self-checking bench for instruction_cache against a line model.
module tb_instruction_cache;

`ifdef ICACHE_PERF_COUNTERS_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        fe_valid_i = 1'b0;
    logic        fe_ready_o;
    logic [31:0] fe_pc_i = '0;
    logic [31:0] fe_act_mask_i = '0;
    logic [2:0]  fe_warp_id_i = '0;
    logic        ic_valid_o;
    logic        dec_ready_i = 1'b1;
    logic [31:0] ic_pc_o;
    logic [31:0] ic_act_mask_o;
    logic [2:0]  ic_warp_id_o;
    logic [31:0] ic_instr_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i = '0;
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;

    int tests_run = 0;
    int tests_failed = 0;
    int mem_req_count = 0;

    // Model: which full PC each line holds and the word stored for it.
    bit          m_valid [16];
    logic [31:0] m_pc    [16];
    logic [31:0] m_data  [16];
    int          m_hits = 0;
    int          m_misses = 0;

    instruction_cache dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .fe_valid_i      (fe_valid_i),
        .fe_ready_o      (fe_ready_o),
        .fe_pc_i         (fe_pc_i),
        .fe_act_mask_i   (fe_act_mask_i),
        .fe_warp_id_i    (fe_warp_id_i),
        .ic_valid_o      (ic_valid_o),
        .dec_ready_i     (dec_ready_i),
        .ic_pc_o         (ic_pc_o),
        .ic_act_mask_o   (ic_act_mask_o),
        .ic_warp_id_o    (ic_warp_id_o),
        .ic_instr_o      (ic_instr_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .hit_count_o     (hit_count_o),
        .miss_count_o    (miss_count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_req_valid_o && mem_req_ready_i) mem_req_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
    endfunction

    task automatic do_fetch(input logic [31:0] pc, input logic [2:0] wid,
                            input logic [31:0] mask, input logic [31:0] word,
                            input int req_stall, input int rsp_delay,
                            input bit flush_mid);
        int          idx;
        bit          exp_hit;
        logic [31:0] exp_instr;
        int          cnt;
        int          reqs0;
        idx       = int'(pc[3:0]);
        exp_hit   = m_valid[idx] && (m_pc[idx] == pc);
        exp_instr = exp_hit ? m_data[idx] : word;
        reqs0     = mem_req_count;
        dec_ready_i   = 1'b1;
        fe_valid_i    = 1'b1;
        fe_pc_i       = pc;
        fe_warp_id_i  = wid;
        fe_act_mask_i = mask;
        #1;
        cnt = 0;
        while (!fe_ready_o && cnt < 20) begin
            tick();
            cnt++;
        end
        tests_run++;
        if (!fe_ready_o) begin
            tests_failed++;
            $display("FAIL fetch_accept_timeout: pc %h fe_ready %b want 1", pc, fe_ready_o);
            fe_valid_i = 1'b0;
            return;
        end
        tick();
        fe_valid_i = 1'b0;
        tests_run++;
        if (ic_valid_o !== exp_hit || mem_req_valid_o !== !exp_hit) begin
            tests_failed++;
            $display("FAIL hit_decision: pc %h ic_valid %b mem_req %b want hit=%b",
                     pc, ic_valid_o, mem_req_valid_o, exp_hit);
        end
        if (!exp_hit) begin
            tests_run++;
            if (mem_req_addr_o !== pc) begin
                tests_failed++;
                $display("FAIL miss_addr: got %h want %h", mem_req_addr_o, pc);
            end
            for (int i = 0; i < req_stall; i++) begin
                tick();
                tests_run++;
                if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== pc) begin
                    tests_failed++;
                    $display("FAIL req_hold: valid %b addr %h want 1 %h",
                             mem_req_valid_o, mem_req_addr_o, pc);
                end
            end
            mem_req_ready_i = 1'b1;
            tick();
            mem_req_ready_i = 1'b0;
            if (flush_mid) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
            end
            for (int i = 0; i < rsp_delay; i++) tick();
            tests_run++;
            if (mem_req_valid_o !== 1'b0 || ic_valid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL miss_wait: mem_req %b ic_valid %b want 0 0",
                         mem_req_valid_o, ic_valid_o);
            end
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = word;
            tick();
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = '0;
            tests_run++;
            if (ic_valid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL miss_latency_early: ic_valid %b want 0 at M+1", ic_valid_o);
            end
            tick();
            tests_run++;
            if (ic_valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL miss_latency: ic_valid %b want 1 at M+2", ic_valid_o);
            end
            tests_run++;
            if (mem_req_count - reqs0 !== 1) begin
                tests_failed++;
                $display("FAIL miss_req_count: got %0d want 1", mem_req_count - reqs0);
            end
            m_misses++;
            if (flush_mid) begin
                model_clear();
            end else begin
                m_valid[idx] = 1'b1;
                m_pc[idx]    = pc;
                m_data[idx]  = word;
            end
        end else begin
            m_hits++;
        end
        tests_run++;
        if (ic_pc_o !== pc || ic_instr_o !== exp_instr ||
            ic_warp_id_o !== wid || ic_act_mask_o !== mask) begin
            tests_failed++;
            $display("FAIL deliver_fields: got pc %h instr %h wid %0d mask %h want %h %h %0d %h",
                     ic_pc_o, ic_instr_o, ic_warp_id_o, ic_act_mask_o,
                     pc, exp_instr, wid, mask);
        end
        if (exp_hit) begin
            tests_run++;
            if (mem_req_count != reqs0) begin
                tests_failed++;
                $display("FAIL hit_no_mem: got %0d reqs want 0", mem_req_count - reqs0);
            end
        end
    endtask

    task automatic check_counters(input string tag);
        logic [31:0] eh, em;
        eh = PerfEn ? 32'(m_hits) : 32'd0;
        em = PerfEn ? 32'(m_misses) : 32'd0;
        tests_run++;
        if (hit_count_o !== eh || miss_count_o !== em) begin
            tests_failed++;
            $display("FAIL counters_%s: got hit %0d miss %0d want %0d %0d",
                     tag, hit_count_o, miss_count_o, eh, em);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        tests_run++;
        if (fe_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_held: got %b want 0", fe_ready_o);
        end
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (fe_ready_o !== 1'b1 || ic_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0 ||
            ic_pc_o !== '0 || ic_instr_o !== '0 || mem_req_addr_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy %b v %b req %b pc %h instr %h addr %h want 1 0 0 0 0 0",
                     fe_ready_o, ic_valid_o, mem_req_valid_o, ic_pc_o, ic_instr_o, mem_req_addr_o);
        end
        model_clear();
        m_hits = 0;
        m_misses = 0;
        check_counters("reset");
    endtask

    task automatic test_cold_miss();
        do_fetch(32'h40, 3'd3, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 2, 3, 1'b0);
        check_counters("cold_miss");
    endtask

    task automatic test_hit();
        do_fetch(32'h40, 3'd5, 32'h0000_F0F0, 32'h0, 0, 0, 1'b0);
        check_counters("hit");
    endtask

    task automatic test_conflict();
        int r0;
        r0 = mem_req_count;
        do_fetch(32'h50, 3'd1, 32'h1234_5678, 32'hCAFE_0050, 0, 1, 1'b0);
        do_fetch(32'h40, 3'd2, 32'h8765_4321, 32'hDEAD_BEEF, 1, 0, 1'b0);
        tests_run++;
        if (mem_req_count - r0 !== 2) begin
            tests_failed++;
            $display("FAIL conflict_evict: got %0d reqs want 2", mem_req_count - r0);
        end
    endtask

    task automatic test_backpressure();
        tick();
        dec_ready_i   = 1'b0;
        fe_valid_i    = 1'b1;
        fe_pc_i       = 32'h40;
        fe_warp_id_i  = 3'd6;
        fe_act_mask_i = 32'h0F0F_0F0F;
        tick();
        fe_valid_i = 1'b0;
        m_hits++;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (ic_valid_o !== 1'b1 || ic_pc_o !== 32'h40 || ic_instr_o !== 32'hDEAD_BEEF ||
                ic_warp_id_o !== 3'd6 || ic_act_mask_o !== 32'h0F0F_0F0F || fe_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold: v %b pc %h instr %h wid %0d mask %h rdy %b",
                         ic_valid_o, ic_pc_o, ic_instr_o, ic_warp_id_o, ic_act_mask_o, fe_ready_o);
            end
            tick();
        end
        dec_ready_i = 1'b1;
        #1;
        tests_run++;
        if (fe_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release: rdy %b want 1", fe_ready_o);
        end
        tick();
        tests_run++;
        if (ic_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_drain: v %b want 0", ic_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        for (int k = 0; k < 4; k++)
            do_fetch(32'h100 + 32'(k), 3'(k), 32'(k) << 4, mem_word(32'h100 + 32'(k)), 0, 0, 1'b0);
        r0 = mem_req_count;
        for (int k = 0; k < 8; k++) begin
            fe_valid_i    = 1'b1;
            fe_pc_i       = 32'h100 + 32'(k % 4);
            fe_warp_id_i  = 3'(k);
            fe_act_mask_i = ~32'(k);
            #1;
            tests_run++;
            if (fe_ready_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_ready: k %0d rdy %b want 1", k, fe_ready_o);
            end
            tick();
            m_hits++;
            tests_run++;
            if (ic_valid_o !== 1'b1 || ic_pc_o !== 32'h100 + 32'(k % 4) ||
                ic_instr_o !== mem_word(32'h100 + 32'(k % 4))) begin
                tests_failed++;
                $display("FAIL stream_out: k %0d v %b pc %h instr %h", k, ic_valid_o, ic_pc_o, ic_instr_o);
            end
        end
        fe_valid_i = 1'b0;
        tests_run++;
        if (mem_req_count != r0) begin
            tests_failed++;
            $display("FAIL stream_no_mem: got %0d reqs want 0", mem_req_count - r0);
        end
        check_counters("stream");
    endtask

    task automatic test_flush_mid_miss();
        do_fetch(32'h1A3, 3'd4, 32'hAAAA_5555, 32'h0BAD_F00D, 1, 2, 1'b1);
        do_fetch(32'h1A3, 3'd4, 32'hAAAA_5555, 32'h0BAD_F00E, 0, 0, 1'b0);
        do_fetch(32'h1A3, 3'd7, 32'h1, 32'h0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                tick();
                flush_i = 1'b1;
                #1;
                tests_run++;
                if (fe_ready_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL flush_blocks_accept: rdy %b want 0", fe_ready_o);
                end
                tick();
                flush_i = 1'b0;
                model_clear();
            end
            pc = 32'h200 + 32'($urandom_range(0, 47));
            do_fetch(pc, 3'($urandom), $urandom, mem_word(pc),
                     $urandom_range(0, 2), $urandom_range(0, 3),
                     $urandom_range(0, 5) == 0);
        end
        check_counters("random");
    endtask

    task automatic test_reset_mid_miss();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        fe_valid_i = 1'b1;
        fe_pc_i    = 32'h77;
        tick();
        fe_valid_i = 1'b0;
        tests_run++;
        if (mem_req_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_req: mem_req %b want 1", mem_req_valid_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h5757_5757;
        tick();
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        tests_run++;
        if (fe_ready_o !== 1'b1 || ic_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0 ||
            ic_pc_o !== '0 || ic_instr_o !== '0 || ic_warp_id_o !== '0 ||
            ic_act_mask_o !== '0 || mem_req_addr_o !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: rdy %b v %b req %b pc %h instr %h addr %h",
                     fe_ready_o, ic_valid_o, mem_req_valid_o, ic_pc_o, ic_instr_o, mem_req_addr_o);
        end
        model_clear();
        m_hits = 0;
        m_misses = 0;
        check_counters("rst_mid");
        do_fetch(32'h77, 3'd2, 32'h3, 32'h1357_9BDF, 0, 0, 1'b0);
        do_fetch(32'h40, 3'd2, 32'h3, 32'hDEAD_BEEF, 0, 0, 1'b0);
        check_counters("after_rst");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_backpressure();
        test_back_to_back();
        test_flush_mid_miss();
        test_random();
        test_reset_mid_miss();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
